reg_bank: RTL
=============

// Module: reg_bank
// PURPOSE
//  32 x 32-bit general-purpose register file of the multicycle CPU.
//  Consumes the 5-bit write-register index from the write-register select mux
//  (rt / sp=29 / ra=31 / rd) and the write-back data; supplies both ALU operand reads.
//  Two asynchronous read ports and one synchronous write port.
//  Register 0 is hardwired to zero. sp comes out of reset at the top-of-stack value.
// PARAMETERS
//  DATA_W    32   register width in bits
//  SP_INDEX  29   index of the stack-pointer register
//  SP_RESET  227  value loaded into register SP_INDEX on reset
//  RA_INDEX  31   index of the return-address register (reset value 0)
// PORTS
//  clk        in   1       system clock; all writes occur on its rising edge
//  reset      in   1       asynchronous, active-high reset
//  RegWrite   in   1       write enable from the control unit
//  ReadReg1   in   5       read port 1 index (instr[25:21], rs)
//  ReadReg2   in   5       read port 2 index (instr[20:16], rt)
//  WriteReg   in   5       write index, driven by the write-register select mux
//  WriteData  in   DATA_W  write-back data from the memory-to-register mux
//  ReadData1  out  DATA_W  contents of register ReadReg1
//  ReadData2  out  DATA_W  contents of register ReadReg2
// BEHAVIOUR
//  - Storage: 32 entries of DATA_W bits. Entry 0 is never written.
//  - Reset:
//    - When reset rises, all entries clear to 0 immediately, without waiting for clk.
//    - Entry SP_INDEX is the exception and loads SP_RESET (227).
//    - While reset is high, writes are ignored. Reads return the reset contents.
//    - Reset asserted in the same cycle as a write wins; the write is lost.
//  - Write: on each rising edge of clk with reset=0 and RegWrite=1, when WriteReg != 0,
//    entry[WriteReg] <= WriteData.
//    - RegWrite=1 with WriteReg=0: no state change.
//    - RegWrite=0: no state change, whatever WriteReg/WriteData hold.
//  - Read: ReadDataN = (ReadRegN == 0) ? 0 : entry[ReadRegN]. Purely combinational, zero latency.
//  - Read/write collision:
//    - A read of the index being written returns the OLD value until the clk edge.
//    - After the edge it returns the new value. There is no write-through bypass.
//    - The multicycle control guarantees operands are latched in a later state.
//  - Both read ports may address the same entry. Both return identical data.
//  - Write data is stored as-is. There is no sign or width transformation; widths match exactly.
//  - Outputs are never X after reset. Every entry has a defined reset value.
//  - The block has no handshake and no stall. One write per cycle at most.
// TESTING
//  1. Reset check. Pulse reset asynchronously, mid-cycle, with no clk edge.
//     -> ReadReg1=29 gives ReadData1=227 at once.
//     -> ReadReg2=31 gives ReadData2=0.
//     -> Every index except 29 reads 0.
//  2. Write/read. RegWrite=1, WriteReg=8, WriteData=32'hDEADBEEF, one clk edge.
//     -> ReadReg1=8 gives 32'hDEADBEEF.
//     -> Before the edge, ReadReg2=8 gives 0 (old value).
//  3. Register 0. RegWrite=1, WriteReg=0, WriteData=32'hFFFFFFFF, edge.
//     -> ReadData1 and ReadData2 at index 0 are both 0.
//  4. Write enable low. Write 5 to reg 31, then RegWrite=0, WriteData=9, WriteReg=31, edge.
//     -> Reg 31 still reads 5.
//  5. Reset beats write. RegWrite=1, WriteReg=29, WriteData=100.
//     Assert reset before the edge and hold it across the edge.
//     -> Reg 29 reads 227 and reg 29 never reads 100.
//  6. Sweep. Write i*3 to regs 1..31 in turn.
//     -> Read back every index on both ports in the same cycle; each matches i*3.
//     -> Reg 0 reads 0.

Source files
------------

// File: rtl/reg_bank.sv
// 32-entry general-purpose register file: two async read ports, one sync write port.
// Entry 0 reads as zero; the stack pointer leaves reset at the top-of-stack value.
module reg_bank #(
  parameter int              DATA_W   = 32,
  parameter int              SP_INDEX = 29,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(227),
  parameter int              RA_INDEX = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [4:0]        ReadReg1,
  input  logic [4:0]        ReadReg2,
  input  logic [4:0]        WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  logic [DATA_W-1:0] regs [32];

  function automatic logic [DATA_W-1:0] rst_val(input int idx);
    logic [DATA_W-1:0] v;
    v = '0;
    if (idx == SP_INDEX)
      v = SP_RESET;
    else if (idx == RA_INDEX)
      v = '0;
    return v;
  endfunction

  // Entry 0 is held at zero; the write guard keeps it from ever changing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= rst_val(i);
    end else if (RegWrite && WriteReg != 5'd0) begin
      regs[WriteReg] <= WriteData;
    end
  end

  assign ReadData1 = (ReadReg1 == 5'd0) ? '0 : regs[ReadReg1];
  assign ReadData2 = (ReadReg2 == 5'd0) ? '0 : regs[ReadReg2];

endmodule
